// File: rtl/nn_pkg.sv
// Shared types and helpers for the sequential neuron layer.
// Holds default widths, the pass FSM encoding, saturation and weight-index packing.
package nn_pkg;

  localparam int unsigned DEF_X_W   = 4;
  localparam int unsigned DEF_W_W   = 8;
  localparam int unsigned DEF_E_W   = 12;
  localparam int unsigned DEF_ACC_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StUpd,
    StDone
  } state_e;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

  // Flat position of weight (neuron j, input i) in the register file.
  function automatic int unsigned widx(input int unsigned j, input int unsigned i,
                                       input int unsigned n_in);
    return j * n_in + i;
  endfunction

endpackage

// File: rtl/nn_mac_sat.sv
// Combinational multiply-accumulate with saturation: y = sat(c +/- ((a * b) >>> SHIFT)).
// a is signed, b is unsigned (zero-extended), result saturates to O_W bits.
module nn_mac_sat import nn_pkg::*; #(
  parameter int unsigned A_W   = DEF_W_W,
  parameter int unsigned B_W   = DEF_X_W,
  parameter int unsigned C_W   = DEF_ACC_W,
  parameter int unsigned O_W   = DEF_ACC_W,
  parameter int unsigned SHIFT = 0,
  parameter bit          SUB   = 1'b0
) (
  input  logic signed [A_W-1:0] a_i,
  input  logic        [B_W-1:0] b_i,
  input  logic signed [C_W-1:0] c_i,
  output logic signed [O_W-1:0] y_o
);

  logic signed [63:0] prod;
  logic signed [63:0] term;
  logic signed [63:0] sum;

  // Full-precision product; the shift applies before the add so no bits are lost early.
  always_comb begin
    prod = 64'(a_i) * signed'(64'(b_i));
    term = prod >>> SHIFT;
    sum  = SUB ? (64'(c_i) - term) : (64'(c_i) + term);
    y_o  = O_W'(saturate(sum, O_W));
  end

endmodule

// File: rtl/neuron_layer_seq.sv
// Time-multiplexed fully-connected layer with an internal weight register file.
// Forward pass accumulates one MAC per cycle; update pass steps one weight per cycle.
module neuron_layer_seq import nn_pkg::*; #(
  parameter int unsigned N_IN     = 4,
  parameter int unsigned N_OUT    = 8,
  parameter int unsigned X_W      = DEF_X_W,
  parameter int unsigned W_W      = DEF_W_W,
  parameter int unsigned E_W      = DEF_E_W,
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned LR_SHIFT = 4,
  parameter bit          RELU     = 1'b1,
  parameter int          W_INIT   = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        start_i,
  input  logic                        mode_i,
  input  logic                        init_i,
  input  logic [N_IN*X_W-1:0]         x_i,
  input  logic [N_OUT*E_W-1:0]        err_i,
  input  logic [N_IN*N_OUT*W_W-1:0]   w_load_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [N_OUT*ACC_W-1:0]      y_o,
  output logic [N_IN*N_OUT*W_W-1:0]   weights_o
);

  localparam int unsigned N_W = N_IN * N_OUT;
  localparam int unsigned IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned KW  = (N_W > 1) ? $clog2(N_W) : 1;

  state_e state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic done_q, done_d;

  logic        [X_W-1:0]   x_q   [N_IN];
  logic signed [E_W-1:0]   err_q [N_OUT];
  logic signed [ACC_W-1:0] y_q   [N_OUT];
  logic signed [W_W-1:0]   w_q   [N_W];

  logic cap_en, load_en, w_wr_en, y_wr_en;
  logic last_i, last_j;
  logic signed [ACC_W-1:0] fwd_c, fwd_sum, y_new;
  logic signed [W_W-1:0]   w_new;

  assign last_i = (i_q == IW'(N_IN - 1));
  assign last_j = (j_q == JW'(N_OUT - 1));

  // The first product of each neuron starts a fresh sum.
  assign fwd_c = (i_q == '0) ? '0 : acc_q;
  assign y_new = (RELU && fwd_sum[ACC_W-1]) ? '0 : fwd_sum;

  nn_mac_sat #(
    .A_W  (W_W),
    .B_W  (X_W),
    .C_W  (ACC_W),
    .O_W  (ACC_W),
    .SHIFT(0),
    .SUB  (1'b0)
  ) u_mac_fwd (
    .a_i(w_q[k_q]),
    .b_i(x_q[i_q]),
    .c_i(fwd_c),
    .y_o(fwd_sum)
  );

  nn_mac_sat #(
    .A_W  (E_W),
    .B_W  (X_W),
    .C_W  (W_W),
    .O_W  (W_W),
    .SHIFT(LR_SHIFT),
    .SUB  (1'b1)
  ) u_mac_upd (
    .a_i(err_q[j_q]),
    .b_i(x_q[i_q]),
    .c_i(w_q[k_q]),
    .y_o(w_new)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    cap_en  = 1'b0;
    load_en = 1'b0;
    w_wr_en = 1'b0;
    y_wr_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (init_i) begin
          load_en = 1'b1;
        end else if (start_i) begin
          cap_en  = 1'b1;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = mode_i ? StUpd : StFwd;
        end
      end
      StFwd, StUpd: begin
        if (state_q == StFwd) begin
          acc_d   = fwd_sum;
          y_wr_en = last_i;
        end else begin
          w_wr_en = 1'b1;
        end
        k_d = k_q + KW'(1);
        if (last_i) begin
          i_d = '0;
          if (last_j) begin
            state_d = StDone;
          end else begin
            j_d = j_q + JW'(1);
          end
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        err_q[j] <= '0;
        y_q[j]   <= '0;
      end
    end else if (en_i) begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      if (cap_en) begin
        for (int i = 0; i < N_IN; i++) x_q[i] <= x_i[i*X_W +: X_W];
        if (mode_i) begin
          for (int j = 0; j < N_OUT; j++) err_q[j] <= err_i[j*E_W +: E_W];
        end
      end
      if (y_wr_en) y_q[j_q] <= y_new;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < N_W; k++) w_q[k] <= W_W'(W_INIT);
    end else if (en_i) begin
      if (load_en) begin
        for (int k = 0; k < N_W; k++) w_q[k] <= w_load_i[k*W_W +: W_W];
      end else if (w_wr_en) begin
        w_q[k_q] <= w_new;
      end
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;

  for (genvar gj = 0; gj < N_OUT; gj++) begin : g_out
    assign y_o[gj*ACC_W +: ACC_W] = y_q[gj];
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_w
      localparam int unsigned K = widx(gj, gi, N_IN);
      assign weights_o[K*W_W +: W_W] = w_q[K];
    end
  end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Scoreboard bench: two layer builds (ReLU/16-bit and pass-through/8-bit) share stimulus;
// expectations come from a plain-arithmetic model and are checked on each done pulse.
module tb_neuron_layer_seq;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int N_W   = N_IN * N_OUT;

  logic clk, rst_i, en_i, start_i, mode_i, init_i;
  logic [15:0] x_i;
  logic [23:0] err_i;
  logic [63:0] w_load_i;
  logic busy_o, done_o, busy2_o, done2_o;
  logic [31:0] y_o;
  logic [15:0] y2_o;
  logic [63:0] weights_o, weights2_o;

  neuron_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(16), .RELU(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .start_i(start_i), .mode_i(mode_i),
    .init_i(init_i), .x_i(x_i), .err_i(err_i), .w_load_i(w_load_i), .busy_o(busy_o),
    .done_o(done_o), .y_o(y_o), .weights_o(weights_o)
  );

  neuron_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(8), .RELU(1'b0)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .start_i(start_i), .mode_i(mode_i),
    .init_i(init_i), .x_i(x_i), .err_i(err_i), .w_load_i(w_load_i), .busy_o(busy2_o),
    .done_o(done2_o), .y_o(y2_o), .weights_o(weights2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y1;
    logic [15:0] y2;
    logic [63:0] w;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  int mx[N_IN];
  int merr[N_OUT];
  int mw[N_W];
  int my1[N_OUT];
  int my2[N_OUT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic logic [63:0] pack_w();
    logic [63:0] p;
    for (int k = 0; k < N_W; k++) p[k*8 +: 8] = 8'(mw[k]);
    return p;
  endfunction

  // Reference: apply one pass to the model state and queue what the DUTs must show at done.
  task automatic model_pass(input bit mode);
    exp_t e;
    int acc1, acc2, d;
    if (!mode) begin
      for (int j = 0; j < N_OUT; j++) begin
        acc1 = 0;
        acc2 = 0;
        for (int i = 0; i < N_IN; i++) begin
          acc1 = sat(acc1 + mw[j*N_IN+i] * mx[i], 16);
          acc2 = sat(acc2 + mw[j*N_IN+i] * mx[i], 8);
        end
        my1[j] = (acc1 < 0) ? 0 : acc1;
        my2[j] = acc2;
      end
    end else begin
      for (int j = 0; j < N_OUT; j++)
        for (int i = 0; i < N_IN; i++) begin
          d = (merr[j] * mx[i]) >>> 4;
          mw[j*N_IN+i] = sat(mw[j*N_IN+i] - d, 8);
        end
    end
    for (int j = 0; j < N_OUT; j++) begin
      e.y1[j*16 +: 16] = 16'(my1[j]);
      e.y2[j*8 +: 8]   = 8'(my2[j]);
    end
    e.w = pack_w();
    sb_q.push_back(e);
  endtask

  // Monitor: every done pulse consumes exactly one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_i && done_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'(done_o), 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("y_relu16", 64'(y_o), 64'(e.y1));
          chk("y_lin8", 64'(y2_o), 64'(e.y2));
          chk("weights", weights_o, e.w);
          chk("weights_b", weights2_o, e.w);
          chk("done_b", 64'(done2_o), 64'd1);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_i = 1'b1;
    for (int k = 0; k < N_W; k++) mw[k] = 1;
    for (int j = 0; j < N_OUT; j++) begin
      my1[j] = 0;
      my2[j] = 0;
    end
  endtask

  // Loads mw; start_i is asserted alongside to confirm init wins.
  task automatic do_init();
    @(negedge clk);
    en_i = 1'b1;
    init_i = 1'b1;
    start_i = 1'b1;
    mode_i = 1'b0;
    w_load_i = pack_w();
    @(posedge clk);
    #1;
    init_i = 1'b0;
    start_i = 1'b0;
    chk("init_beats_start", 64'(busy_o), 64'd0);
    chk("init_weights", weights_o, pack_w());
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N_IN; i++) x_i[i*4 +: 4] = 4'(mx[i]);
    for (int j = 0; j < N_OUT; j++) err_i[j*12 +: 12] = 12'(merr[j]);
  endtask

  task automatic run_pass(input bit mode, input int stall_at, input int stall_len,
                          input bit poke);
    int lat;
    bit got;
    @(negedge clk);
    en_i = 1'b1;
    drive_inputs();
    start_i = 1'b1;
    init_i = 1'b0;
    mode_i = mode;
    model_pass(mode);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      en_i = !(stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len);
      if (poke) begin
        start_i  = 1'($urandom);
        init_i   = 1'($urandom);
        mode_i   = 1'($urandom);
        x_i      = 16'($urandom);
        err_i    = 24'($urandom);
        w_load_i = {$urandom, $urandom};
      end
      @(posedge clk);
      lat++;
      #1;
      if (done_o) begin
        got = 1'b1;
        start_i = 1'b0;
        init_i = 1'b0;
        en_i = 1'b1;
      end
    end
    chk("done_latency", 64'(lat), 64'(9 + stall_len));
    chk("busy_clear_at_done", 64'(busy_o), 64'd0);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N_IN; i++) mx[i] = int'($urandom_range(0, 15));
    for (int j = 0; j < N_OUT; j++) merr[j] = int'($urandom_range(0, 4095)) - 2048;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_i = 1'b0; en_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; init_i = 1'b0;
    x_i = '0; err_i = '0; w_load_i = '0;
    do_reset();
    #1;
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_y", 64'(y_o), 64'd0);
    chk("reset_y_b", 64'(y2_o), 64'd0);
    chk("reset_weights", weights_o, 64'h0101_0101_0101_0101);

    // Forward with reset weights.
    for (int i = 0; i < N_IN; i++) mx[i] = i + 1;
    run_pass(1'b0, 0, 0, 1'b0);

    // Negative weights: ReLU clamps, the pass-through build keeps -10.
    for (int k = 0; k < N_W; k++) mw[k] = -1;
    do_init();
    run_pass(1'b0, 0, 0, 1'b0);

    // Gradient step from reset weights, y_o from the preceding forward pass must persist.
    do_reset();
    run_pass(1'b0, 0, 0, 1'b0);
    for (int j = 0; j < N_OUT; j++) merr[j] = 64;
    run_pass(1'b1, 0, 0, 1'b0);

    // Saturation of the weight and of the 8-bit accumulator.
    for (int k = 0; k < N_W; k++) mw[k] = 100;
    do_init();
    for (int i = 0; i < N_IN; i++) mx[i] = 15;
    for (int j = 0; j < N_OUT; j++) merr[j] = -2048;
    run_pass(1'b1, 0, 0, 1'b0);
    run_pass(1'b0, 0, 0, 1'b0);

    // Stall mid-forward, then inputs poked while busy.
    for (int k = 0; k < N_W; k++) mw[k] = int'($urandom_range(0, 255)) - 128;
    do_init();
    rand_inputs();
    run_pass(1'b0, 3, 5, 1'b0);
    rand_inputs();
    run_pass(1'b1, 0, 0, 1'b1);
    rand_inputs();
    run_pass(1'b0, 0, 0, 1'b1);

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < N_W; k++) mw[k] = int'($urandom_range(0, 255)) - 128;
        do_init();
      end
      rand_inputs();
      run_pass(1'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
               1'($urandom));
    end

    // Asynchronous reset in the middle of an update pass.
    rand_inputs();
    @(negedge clk);
    drive_inputs();
    start_i = 1'b1;
    mode_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_i = 1'b0;
    #1;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    chk("abort_weights", weights_o, 64'h0101_0101_0101_0101);
    chk("abort_weights_b", weights2_o, 64'h0101_0101_0101_0101);
    @(negedge clk);
    rst_i = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done_o) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/neuron_layer_seq.md
Name: neuron_layer_seq

Overview:
- Parametrised, time-multiplexed fully-connected layer: N_OUT neurons, each over N_IN inputs, all sharing one MAC.
- Holds its own weight register file. Two modes:
  - forward pass: weighted sum, optional ReLU;
  - weight-update pass: gradient step with shift-based learning rate.
- Successor to the fixed 8x4 hidden-neuron bank with hard-wired weights. Sits between the training state machine and the output neuron/backprop stages.
- Handshake is start/busy/done; the state machine no longer counts cycles.

Parameters:
- N_IN, 4, inputs per neuron (>=1)
- N_OUT, 8, neurons in layer (>=1)
- X_W, 4, input width, unsigned
- W_W, 8, weight width, signed two's complement
- E_W, 12, error-term width, signed
- ACC_W, 16, accumulator/output width, signed, saturating
- LR_SHIFT, 4, learning-rate right-shift (arithmetic)
- RELU, 1, 1 = clamp negative outputs to 0; 0 = pass through
- W_INIT, 1, reset value of every weight

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- en_i  in  1  global enable; low = stall (all state held)
- start_i  in  1  begin a pass; sampled only in IDLE
- mode_i  in  1  0 = forward, 1 = weight update; sampled with start_i
- init_i  in  1  bulk weight load from w_load_i; honoured only in IDLE
- x_i  in  N_IN*X_W  input vector; element i at [i*X_W +: X_W]
- err_i  in  N_OUT*E_W  per-neuron error terms for update
- w_load_i  in  N_IN*N_OUT*W_W  weights; index j*N_IN+i
- busy_o  out  1  pass in progress
- done_o  out  1  one-cycle completion pulse
- y_o  out  N_OUT*ACC_W  neuron outputs, registered
- weights_o  out  N_IN*N_OUT*W_W  current weights, same packing as w_load_i

Behaviour:
- Interface (already decided): one clock, clk_i; rst_i is asynchronous, active-low.
- Reset values:
  - FSM = IDLE; busy_o = 0; done_o = 0; y_o = 0.
  - All weights = W_INIT; accumulator and counters = 0.
- Every state update is qualified by en_i. With en_i low nothing changes, and done_o holds its value.
- States: IDLE, FWD, UPD, DONE.
- IDLE:
  - init_i=1 loads all weights from w_load_i in one cycle.
  - init_i has priority over start_i in the same cycle; start_i is then ignored.
  - start_i=1 captures x_i (and err_i if mode_i=1) into internal registers.
  - Transition: mode_i=0 -> FWD; mode_i=1 -> UPD.
- FWD:
  - Counters j (neuron) and i (input), row-major, one MAC per cycle.
  - i=0: acc = w[j][i]*x[i]; otherwise acc = acc + w[j][i]*x[i].
  - x is zero-extended; the product is signed.
  - acc saturates at ±(2^(ACC_W-1)) bounds on every add.
  - On i=N_IN-1: y_o[j] <= (RELU && acc<0) ? 0 : acc.
  - After the last neuron -> DONE.
- UPD:
  - One weight per cycle, same order as FWD.
  - delta = (err[j]*x[i]) >>> LR_SHIFT, full precision before the shift.
  - w[j][i] <= sat_W_W(w[j][i] - delta).
  - y_o is unchanged. After the last weight -> DONE.
- DONE: done_o=1 for exactly one cycle, then -> IDLE.
- Latency: done_o is high in the cycle following the (N_IN*N_OUT+1)th enabled edge after the edge that sampled start_i.
- busy_o is 1 in FWD, UPD and DONE.
- Ignored inputs:
  - start_i and init_i while busy_o=1.
  - Changes on x_i/err_i during a pass (inputs are captured at start).
- y_o holds until overwritten, neuron by neuron, during the next forward pass.
- Reset mid-pass aborts immediately: weights return to W_INIT and no done_o is produced.
- weights_o is a direct view of the register file; an update to weight k is visible the cycle after it is written.

Decomposition:
- Shared package nn_pkg:
  - state enum: IDLE/FWD/UPD/DONE;
  - saturate function (value, width);
  - packing-index helper;
  - default width constants (X_W, W_W, E_W, ACC_W).
- One natural sub-module: nn_mac_sat. Combinational multiply plus saturating add/subtract, reused for both the forward accumulate and the weight update.

Test Plan:
All tests use N_IN=4, N_OUT=2 unless noted.
- Forward, reset weights: reset; start_i, mode_i=0, x=(1,2,3,4).
  - Expect y_o = (10,10).
  - done_o pulses 9 edges after the start edge, for 1 cycle.
- ReLU clamp: init_i with all weights -1; forward x=(1,2,3,4).
  - RELU=1: y_o = (0,0).
  - RELU=0 build: y_o = (-10,-10).
- Update step: reset weights 1; err=(64,64); x=(1,2,3,4); LR_SHIFT=4; mode_i=1.
  - Expect neuron 0 weights = (-3,-7,-11,-15), identical for neuron 1.
  - y_o unchanged; done_o after 9 edges.
- Saturation:
  - Weight 100, err=-2048, x=15: weight -> 127.
  - ACC_W=8 build, weights 127, x=15: y_o = 127.
- Stall and ignore:
  - en_i low 5 cycles mid-FWD: done_o delayed by exactly 5 cycles, same y_o.
  - start_i or init_i while busy_o=1: no effect.
- Async reset mid-UPD: rst_i low between edges. Immediately busy_o=0 and weights_o all W_INIT; no done_o pulse.
